// File: rtl/breakout_pkg.sv
// Shared constants for the breakout ball and sound blocks: tone encodings and clock-derived timing.
// Pure declarations; no logic, no latency, no flow control.
// Tone half-periods are rounded to the nearest clk cycle so both blocks agree.
package breakout_pkg;

    localparam int CLK_HZ    = 25000000;
    localparam int TONE1_HZ  = 880;
    localparam int TONE2_HZ  = 440;
    localparam int BURST_DIV = 10;

    localparam int TONE1_HALF_DEF = (CLK_HZ + TONE1_HZ) / (2 * TONE1_HZ);
    localparam int TONE2_HALF_DEF = (CLK_HZ + TONE2_HZ) / (2 * TONE2_HZ);
    localparam int DUR_CYCLES_DEF = CLK_HZ / BURST_DIV;

    typedef enum logic [1:0] {
        TONE_NONE   = 2'd0,
        TONE_WALL   = 2'd1,
        TONE_PADDLE = 2'd2
    } tone_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } fx_state_t;

endpackage

// File: rtl/tone_osc.sv
// Square-wave oscillator: half-period down-counter with a phase toggle.
// Load gives phase=1 on the next edge; phase holds for half_val+1 cycles per level.
// No backpressure; when neither load nor run is asserted the oscillator parks low.
module tone_osc #(
    parameter int HALF_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [HALF_W-1:0] half_val,
    input  logic              run,
    output logic              phase
);

    logic [HALF_W-1:0] half_cnt;

    // half_val is the reload value (half-period minus one)
    always_ff @(posedge clk) begin
        if (reset) begin
            half_cnt <= '0;
            phase    <= 1'b0;
        end else if (load) begin
            half_cnt <= half_val;
            phase    <= 1'b1;
        end else if (run) begin
            if (half_cnt == '0) begin
                half_cnt <= half_val;
                phase    <= ~phase;
            end else begin
                half_cnt <= half_cnt - 1'b1;
            end
        end else begin
            half_cnt <= '0;
            phase    <= 1'b0;
        end
    end

endmodule

// File: rtl/sound_fx.sv
// Turns rising edges of the ball-logic sound flags into fixed-length square-wave bursts.
// A rise sampled at edge N shows busy/tone_id/speaker after edge N; burst lasts DUR_CYCLES.
// No backpressure; a new rise mid-burst restarts the burst, paddle wins simultaneous rises.
module sound_fx
    import breakout_pkg::*;
#(
    parameter int TONE1_HALF = TONE1_HALF_DEF,
    parameter int TONE2_HALF = TONE2_HALF_DEF,
    parameter int DUR_CYCLES = DUR_CYCLES_DEF,
    parameter int HALF_W     = 16,
    parameter int DUR_W      = 22
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       play_sound1,
    input  logic       play_sound2,
    input  logic       mute,
    output logic       speaker,
    output logic       busy,
    output logic [1:0] tone_id
);

    localparam logic [HALF_W-1:0] HALF1_RELOAD = HALF_W'(TONE1_HALF - 1);
    localparam logic [HALF_W-1:0] HALF2_RELOAD = HALF_W'(TONE2_HALF - 1);
    localparam logic [DUR_W-1:0]  DUR_RELOAD   = DUR_W'(DUR_CYCLES - 1);

    fx_state_t         state, state_nxt;
    tone_t             tone_q, tone_nxt, tone_sel, half_tone;
    logic [DUR_W-1:0]  dur_cnt, dur_nxt;
    logic              prev1, prev2;
    logic              rise1, rise2, trig;
    logic              osc_load, osc_run, phase;
    logic [HALF_W-1:0] half_val;

    assign rise1    = play_sound1 & ~prev1;
    assign rise2    = play_sound2 & ~prev2;
    assign trig     = rise1 | rise2;
    assign tone_sel = rise2 ? TONE_PADDLE : TONE_WALL;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            tone_q  <= TONE_NONE;
            dur_cnt <= '0;
            prev1   <= 1'b0;
            prev2   <= 1'b0;
        end else begin
            state   <= state_nxt;
            tone_q  <= tone_nxt;
            dur_cnt <= dur_nxt;
            prev1   <= play_sound1;
            prev2   <= play_sound2;
        end
    end

    always_comb begin
        state_nxt = state;
        tone_nxt  = tone_q;
        dur_nxt   = dur_cnt;
        osc_load  = 1'b0;
        osc_run   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trig) begin
                    state_nxt = ST_PLAY;
                    tone_nxt  = tone_sel;
                    dur_nxt   = DUR_RELOAD;
                    osc_load  = 1'b1;
                end
            end
            ST_PLAY: begin
                if (trig) begin
                    tone_nxt = tone_sel;
                    dur_nxt  = DUR_RELOAD;
                    osc_load = 1'b1;
                end else if (dur_cnt == '0) begin
                    state_nxt = ST_IDLE;
                    tone_nxt  = TONE_NONE;
                end else begin
                    dur_nxt = dur_cnt - 1'b1;
                    osc_run = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // On a trigger the new tone's half-period must be loaded, not the old one
    assign half_tone = osc_load ? tone_sel : tone_q;
    assign half_val  = (half_tone == TONE_PADDLE) ? HALF2_RELOAD : HALF1_RELOAD;

    tone_osc #(
        .HALF_W (HALF_W)
    ) u_tone_osc (
        .clk      (clk),
        .reset    (reset),
        .load     (osc_load),
        .half_val (half_val),
        .run      (osc_run),
        .phase    (phase)
    );

    // Gating the registered phase keeps speaker edges aligned with busy
    assign speaker = phase & ~mute;
    assign busy    = (state == ST_PLAY);
    assign tone_id = tone_q;

endmodule

// File: doc/sound_fx.md
Name: sound_fx

Overview:
- Downstream consumer of the ball logic's `play_sound1` (wall/block hit) and `play_sound2` (paddle hit) flags.
- Converts each new event into a fixed-length square-wave tone burst on a single speaker pin.
- Runs on the same `clk` as the ball logic; its output drives the board's piezo/audio pin directly.

Parameters:
- TONE1_HALF, 14205, half-period in clk cycles for sound 1 (880 Hz at 25 MHz).
- TONE2_HALF, 28409, half-period in clk cycles for sound 2 (440 Hz at 25 MHz).
- DUR_CYCLES, 2500000, burst length in clk cycles (100 ms at 25 MHz).
- HALF_W, 16, half-period counter width; must hold max(TONE1_HALF, TONE2_HALF).
- DUR_W, 22, duration counter width; must hold DUR_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- play_sound1  in  1  level flag from ball logic, wall/block hit
- play_sound2  in  1  level flag from ball logic, paddle hit
- mute  in  1  1 = force speaker low; sequencing continues
- speaker  out  1  square-wave output
- busy  out  1  1 while a burst is in progress
- tone_id  out  2  0 = idle, 1 = sound 1 playing, 2 = sound 2 playing

Behaviour:
- Single clock `clk`; reset is synchronous and active-high. Everything updates on the posedge of `clk` only.
- Reset values: speaker=0, busy=0, tone_id=0, FSM=IDLE, both counters=0, edge registers prev1/prev2=0.
- Edge detection:
  - rise1 = play_sound1 & ~prev1; rise2 = play_sound2 & ~prev2.
  - prev1/prev2 register the inputs every cycle.
  - A flag held high for many cycles produces exactly one burst.
- Trigger selection: if rise2, select tone 2; else if rise1, select tone 1. Paddle has priority on a simultaneous rise.
- FSM states:
  - IDLE to PLAY on any rise.
  - PLAY to PLAY (restart) on any rise.
  - PLAY to IDLE when the duration counter is 0 and no rise occurs in that cycle.
- On a trigger cycle (from IDLE or PLAY):
  - tone_id set to the selected tone.
  - Internal phase register set to 1.
  - half counter loaded with HALF(sel)-1.
  - dur counter loaded with DUR_CYCLES-1.
  - busy set to 1.
  - Latency: a rise sampled at edge N gives busy=1 and phase=1 after edge N.
- In PLAY without a trigger:
  - dur counter decrements each cycle.
  - half counter decrements; when it is 0 it reloads HALF(tone_id)-1 and phase toggles.
  - Phase therefore stays high for exactly HALF cycles, then low for HALF cycles.
- End of burst: the cycle with dur==0 and no rise returns to IDLE; phase=0, busy=0, tone_id=0. busy is high for exactly DUR_CYCLES cycles per uninterrupted burst.
- Retrigger mid-burst: always restarts the full duration, with phase restarting high. Tone is switched or kept per the priority rule. A burst is never extended by partial amounts.
- Output mapping: speaker = phase & ~mute, registered. mute never affects busy, tone_id or the counters.
- Reset mid-burst: the next edge forces all reset values regardless of triggers in the same cycle. prev regs clear to 0, so an input still high after reset retriggers once.
- Counters are unsigned, with no wrap: loads occur before any decrement could pass 0.
- Parameter constraints: HALF >= 1 and DUR_CYCLES >= 1. With HALF=1 the speaker toggles every cycle.

Decomposition:
- Shared package `breakout_pkg`:
  - tone_id encodings TONE_NONE=0, TONE_WALL=1, TONE_PADDLE=2.
  - Default CLK_HZ=25000000 and the derived half-period/duration constants, so ball and sound blocks agree.
- One sub-module, `tone_osc`:
  - Half-period down-counter plus phase toggle.
  - Ports: clk, reset, load, half_val, run, phase.
  - sound_fx holds the edge detectors, priority logic, FSM and duration counter.

Test Plan:
Bench parameters: TONE1_HALF=4, TONE2_HALF=8, DUR_CYCLES=40.
- Hold reset 3 cycles, inputs 0 -> speaker=0, busy=0, tone_id=0 throughout and after release.
- 1-cycle pulse on play_sound1 -> busy=1 for exactly 40 cycles starting the cycle after the sample; tone_id=1; speaker pattern 1111 0000 repeated 5 times; then speaker=0, busy=0.
- play_sound2 held high 100 cycles -> exactly one 40-cycle burst, tone_id=2, speaker high 8 / low 8; no second burst while held.
- play_sound1 and play_sound2 rise in the same cycle -> tone_id=2, half-period 8.
- Sound-1 burst, then play_sound2 rises on burst cycle 20 -> tone_id becomes 2, speaker restarts high, busy lasts 40 more cycles (60 total).
- Reset at burst cycle 10 -> next cycle speaker=0, busy=0, tone_id=0.
- Separate run with mute=1 during a burst -> speaker=0 while busy and tone_id still follow the normal 40-cycle timing.
